// File: rtl/alu_pkg.sv
// Shared constants, types and control-packet packing helpers for the ALU
// result path.
package alu_pkg;

  localparam int PKT_BITS = 11;
  localparam logic [2:0] CTL_IDX = 3'd4;

  typedef enum logic {PKT_DATA = 1'b0, PKT_CTL = 1'b1} packet_t;
  typedef enum logic {ST_OK = 1'b0, ST_ERROR = 1'b1} status_t;
  typedef enum logic [1:0] {IDLE, LOAD_PKT, SHIFT, GAP} tx_state_t;

  function automatic logic [7:0] pack_ctl_ok(input logic [3:0] flags,
                                             input logic [2:0] crc3);
    return {1'b0, flags, crc3};
  endfunction

  function automatic logic [7:0] pack_ctl_err(input logic [5:0] err_flags,
                                              input logic       parity);
    return {1'b1, err_flags, parity};
  endfunction

endpackage

// File: rtl/alu_pkt_shifter.sv
// 11-bit packet shift register; shifts in ones so the line idles high once
// the stop bit has gone out.
module alu_pkt_shifter
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  packet_t    pkt_type,
  input  logic [7:0] d,
  output logic       sout_bit,
  output logic       last_bit
);

  logic [PKT_BITS-1:0] sh_q, sh_d;
  logic [3:0]          cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = {1'b0, pkt_type, d, 1'b1};
      cnt_d = 4'd0;
    end else begin
      sh_d = {sh_q[PKT_BITS-2:0], 1'b1};
      // Counter saturates on the stop bit so gap/idle cycles keep last_bit high.
      if (cnt_q != 4'(PKT_BITS - 1)) cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '1;
      cnt_q <= 4'd0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign sout_bit = sh_q[PKT_BITS-1];
  assign last_bit = (cnt_q == 4'(PKT_BITS - 1));

endmodule

// File: rtl/alu_result_tx.sv
// ALU result transmitter: serialises a captured result record as four DATA
// packets plus one CTL packet, or a single CTL packet for an error record.
module alu_result_tx
  import alu_pkg::*;
#(
  parameter int GAP_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        err,
  input  logic [31:0] C,
  input  logic [3:0]  flags,
  input  logic [2:0]  crc3,
  input  logic [5:0]  err_flags,
  input  logic        parity,
  output logic        sout,
  output logic        tx_done
);

  localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  tx_state_t   state_q, state_d;
  logic [2:0]  pkt_idx_q, pkt_idx_d;
  logic [3:0]  gap_q, gap_d;
  logic        tx_done_q, tx_done_d;
  status_t     status_q, status_d;
  logic [31:0] c_q, c_d;
  logic [3:0]  flags_q, flags_d;
  logic [2:0]  crc_q, crc_d;
  logic [5:0]  ef_q, ef_d;
  logic        par_q, par_d;

  logic        load;
  logic        pkt_end;
  logic        last_bit;
  logic [7:0]  ld_byte;
  packet_t     ld_type;

  always_comb begin
    state_d   = state_q;
    pkt_idx_d = pkt_idx_q;
    gap_d     = gap_q;
    tx_done_d = 1'b0;
    status_d  = status_q;
    c_d       = c_q;
    flags_d   = flags_q;
    crc_d     = crc_q;
    ef_d      = ef_q;
    par_d     = par_q;
    load      = 1'b0;
    pkt_end   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          status_d  = err ? ST_ERROR : ST_OK;
          c_d       = C;
          flags_d   = flags;
          crc_d     = crc3;
          ef_d      = err_flags;
          par_d     = parity;
          pkt_idx_d = err ? CTL_IDX : 3'd0;
          load      = 1'b1;
          state_d   = LOAD_PKT;
        end
      end
      LOAD_PKT: state_d = SHIFT;
      SHIFT: begin
        if (last_bit) begin
          if (GAP_BITS > 0) begin
            gap_d   = 4'd0;
            state_d = GAP;
          end else begin
            pkt_end = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) pkt_end = 1'b1;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // End of a packet (stop bit plus any gap): chain the next one or finish.
    if (pkt_end) begin
      if (pkt_idx_q != CTL_IDX) begin
        pkt_idx_d = pkt_idx_q + 3'd1;
        load      = 1'b1;
        state_d   = LOAD_PKT;
      end else begin
        tx_done_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  // Byte select uses the _d values so the accept edge can load straight from the inputs.
  always_comb begin
    ld_type = (pkt_idx_d == CTL_IDX) ? PKT_CTL : PKT_DATA;
    unique case (pkt_idx_d)
      3'd0:    ld_byte = c_d[31:24];
      3'd1:    ld_byte = c_d[23:16];
      3'd2:    ld_byte = c_d[15:8];
      3'd3:    ld_byte = c_d[7:0];
      default: ld_byte = (status_d == ST_ERROR) ? pack_ctl_err(ef_d, par_d)
                                                : pack_ctl_ok(flags_d, crc_d);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pkt_idx_q <= 3'd0;
      gap_q     <= 4'd0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_idx_q <= pkt_idx_d;
      gap_q     <= gap_d;
      tx_done_q <= tx_done_d;
    end
  end

  always_ff @(posedge clk) begin
    status_q <= status_d;
    c_q      <= c_d;
    flags_q  <= flags_d;
    crc_q    <= crc_d;
    ef_q     <= ef_d;
    par_q    <= par_d;
  end

  alu_pkt_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .pkt_type (ld_type),
    .d        (ld_byte),
    .sout_bit (sout),
    .last_bit (last_bit)
  );

  assign in_ready = (state_q == IDLE);
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: unit 0 has no inter-packet gap, unit 1 has a
// 2-cycle gap; streams are compared against a packet-level model.
module tb_alu_result_tx;

  typedef struct packed {
    bit        err;
    bit [31:0] c;
    bit [3:0]  flags;
    bit [2:0]  crc;
    bit [5:0]  ef;
    bit        par;
  } rec_t;

  typedef struct packed {
    rec_t      r;
    bit [54:0] exp_bits;
    int        exp_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_s [2];
  logic        in_ready_s [2];
  logic        err_s      [2];
  logic [31:0] c_s        [2];
  logic [3:0]  flags_s    [2];
  logic [2:0]  crc_s      [2];
  logic [5:0]  ef_s       [2];
  logic        par_s      [2];
  logic        sout_s     [2];
  logic        tx_done_s  [2];

  int   checks = 0;
  int   failures = 0;
  int   tx_pulses [2];
  bit   exp_q [$];
  bit   got_q [$];
  rec_t zero_r = '0;
  int   gap_of [2] = '{0, 2};

  always #5 clk = ~clk;

  alu_result_tx #(.GAP_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .err(err_s[0]), .C(c_s[0]), .flags(flags_s[0]), .crc3(crc_s[0]),
    .err_flags(ef_s[0]), .parity(par_s[0]), .sout(sout_s[0]), .tx_done(tx_done_s[0])
  );

  alu_result_tx #(.GAP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .err(err_s[1]), .C(c_s[1]), .flags(flags_s[1]), .crc3(crc_s[1]),
    .err_flags(ef_s[1]), .parity(par_s[1]), .sout(sout_s[1]), .tx_done(tx_done_s[1])
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Packet-level model: list of {type, byte}, each framed as start/type/byte/stop plus gap.
  function automatic void build_exp(rec_t r, int gap);
    bit [8:0] pk [$];
    exp_q.delete();
    if (r.err) pk.push_back({1'b1, 1'b1, r.ef, r.par});
    else begin
      for (int i = 3; i >= 0; i--) pk.push_back({1'b0, 8'(r.c >> (8 * i))});
      pk.push_back({1'b1, 1'b0, r.flags, r.crc});
    end
    foreach (pk[j]) begin
      exp_q.push_back(1'b0);
      for (int b = 8; b >= 0; b--) exp_q.push_back(pk[j][b]);
      exp_q.push_back(1'b1);
      for (int g = 0; g < gap; g++) exp_q.push_back(1'b1);
    end
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.err   = ($urandom_range(0, 3) == 0);
    r.c     = $urandom;
    r.flags = 4'($urandom);
    r.crc   = 3'($urandom);
    r.ef    = 6'($urandom);
    r.par   = 1'($urandom);
    return r;
  endfunction

  task automatic apply(input int u, input rec_t r);
    err_s[u]   = r.err;
    c_s[u]     = r.c;
    flags_s[u] = r.flags;
    crc_s[u]   = r.crc;
    ef_s[u]    = r.ef;
    par_s[u]   = r.par;
  endtask

  task automatic accept_rec(input int u, input rec_t r);
    @(negedge clk);
    chk("ready_before_accept", 64'(in_ready_s[u]), 64'd1);
    apply(u, r);
    in_valid_s[u] = 1'b1;
    @(posedge clk);
  endtask

  // Follows one record from the cycle after its accept edge through its tx_done cycle.
  task automatic observe(input int u, input rec_t r, input bit has_next,
                         input rec_t nxt, input bit scramble, input string name);
    int n;
    int done_cyc = 0;
    int extra = 0;
    int bad = 0;
    build_exp(r, gap_of[u]);
    n = exp_q.size();
    got_q.delete();
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k <= n) got_q.push_back(sout_s[u]);
      if (tx_done_s[u]) begin
        if (done_cyc == 0) done_cyc = k;
        else extra++;
      end
      if (k == n + 1) begin
        chk({name, "_ready_at_done"}, 64'(in_ready_s[u]), 64'd1);
        chk({name, "_idle_sout"}, 64'(sout_s[u]), 64'd1);
      end
      if (k == 1) begin
        in_valid_s[u] = has_next;
        if (has_next) apply(u, nxt);
      end
      if (scramble && !has_next) apply(u, rand_rec());
    end
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
    chk({name, "_stream_bad_bits"}, 64'(bad), 64'd0);
    chk({name, "_done_cycle"}, 64'(done_cyc + extra * 1000), 64'(n + 1));
    tx_pulses[u] += (done_cyc != 0 ? 1 : 0) + extra;
  endtask

  vec_t tbl [4];

  initial begin
    int p0;
    int seen;
    logic [54:0] g;
    rec_t a, b;

    tbl[0] = '{r: '{err: 1'b0, c: 32'h12345678, flags: 4'b1010, crc: 3'b101, ef: 6'h0, par: 1'b0},
               exp_bits: {11'b00000100101, 11'b00001101001, 11'b00010101101,
                          11'b00011110001, 11'b01010101011}, exp_len: 55};
    tbl[1] = '{r: '{err: 1'b1, c: 32'hFFFFFFFF, flags: 4'hF, crc: 3'h7, ef: 6'b100100, par: 1'b1},
               exp_bits: {11'b01110010011, 44'd0}, exp_len: 11};
    tbl[2] = '{r: '{err: 1'b0, c: 32'h0, flags: 4'h0, crc: 3'h0, ef: 6'h3F, par: 1'b1},
               exp_bits: {11'b00000000001, 11'b00000000001, 11'b00000000001,
                          11'b00000000001, 11'b01000000001}, exp_len: 55};
    tbl[3] = '{r: '{err: 1'b1, c: 32'h0, flags: 4'h0, crc: 3'h0, ef: 6'h0, par: 1'b0},
               exp_bits: {11'b01100000001, 44'd0}, exp_len: 11};

    tx_pulses[0] = 0;
    tx_pulses[1] = 0;
    for (int u = 0; u < 2; u++) begin
      in_valid_s[u] = 1'b0;
      apply(u, zero_r);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_sout", 64'(sout_s[u]), 64'd1);
      chk("reset_ready", 64'(in_ready_s[u]), 64'd1);
      chk("reset_done", 64'(tx_done_s[u]), 64'd0);
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      accept_rec(0, tbl[i].r);
      observe(0, tbl[i].r, 1'b0, zero_r, 1'b1, "table");
      g = '0;
      for (int j = 0; j < tbl[i].exp_len; j++) g[54 - j] = got_q[j];
      chk("table_literal", 64'(g), 64'(tbl[i].exp_bits));
    end

    for (int i = 0; i < 20; i++) begin
      a = rand_rec();
      accept_rec(0, a);
      observe(0, a, 1'b0, zero_r, 1'($urandom), "rand_g0");
    end

    p0 = tx_pulses[0];
    a = '{err: 1'b0, c: 32'hA5A5A5A5, flags: 4'h3, crc: 3'h6, ef: 6'h0, par: 1'b0};
    b = '{err: 1'b1, c: 32'h0, flags: 4'h0, crc: 3'h0, ef: 6'b010110, par: 1'b0};
    accept_rec(0, a);
    observe(0, a, 1'b1, b, 1'b0, "b2b_first");
    observe(0, b, 1'b0, zero_r, 1'b0, "b2b_second");
    chk("b2b_done_pulses", 64'(tx_pulses[0] - p0), 64'd2);

    a = '0;
    accept_rec(1, a);
    observe(1, a, 1'b0, zero_r, 1'b0, "gap2_zero");
    for (int i = 0; i < 4; i++) begin
      a = rand_rec();
      accept_rec(1, a);
      observe(1, a, 1'b0, zero_r, 1'b1, "rand_g2");
    end

    // Abort inside the third data packet (cycles 23..33 after accept).
    a = '{err: 1'b0, c: 32'h12345678, flags: 4'hA, crc: 3'h5, ef: 6'h0, par: 1'b0};
    accept_rec(0, a);
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sout", 64'(sout_s[0]), 64'd1);
    chk("abort_ready", 64'(in_ready_s[0]), 64'd1);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (tx_done_s[0] || !sout_s[0]) seen++;
      @(negedge clk);
    end
    chk("abort_quiet_cycles", 64'(seen), 64'd0);
    a = '{err: 1'b0, c: 32'h00000001, flags: 4'h0, crc: 3'h1, ef: 6'h0, par: 1'b0};
    accept_rec(0, a);
    observe(0, a, 1'b0, zero_r, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
